// File: rtl/loader_pkg.sv
// Shared definitions for the operand loader and the ALU datapath top.
package loader_pkg;

  localparam int unsigned LOADER_WIDTH = 4;
  localparam int unsigned LOADER_SEL_W = 2;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, counting debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The level only flips once the synchronised input has disagreed with it
  // for long enough; the pulse is raised on the same edge the level rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      rise_pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          level      <= sync2;
          cnt        <= '0;
          rise_pulse <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Turns a shared switch bank and load/clear buttons into a stable
// operand/opcode bus for the ALU datapath.
module operand_loader
  import loader_pkg::*;
#(
  parameter int unsigned WIDTH           = LOADER_WIDTH,
  parameter int unsigned SEL_W           = LOADER_SEL_W,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic [SEL_W-1:0] sel,
  output logic             oe,
  output logic [1:0]       state
);

  logic          load_p;
  logic          clear_p;
  logic          load_level;
  logic          clear_level;
  logic          unused_levels;

  loader_state_t state_q;
  loader_state_t state_nx;
  logic [WIDTH-1:0] in0_nx;
  logic [WIDTH-1:0] in1_nx;
  logic [SEL_W-1:0] sel_nx;
  logic             oe_nx;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_load),
    .level      (load_level),
    .rise_pulse (load_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_clear),
    .level      (clear_level),
    .rise_pulse (clear_p)
  );

  // Debounced levels are only of interest to LED/debug wrappers.
  assign unused_levels = load_level ^ clear_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      in0     <= '0;
      in1     <= '0;
      sel     <= '0;
      oe      <= 1'b0;
    end else begin
      state_q <= state_nx;
      in0     <= in0_nx;
      in1     <= in1_nx;
      sel     <= sel_nx;
      oe      <= oe_nx;
    end
  end

  // Clear beats load; captured values persist across the SHOW->GET_A wrap.
  always_comb begin
    state_nx = state_q;
    in0_nx   = in0;
    in1_nx   = in1;
    sel_nx   = sel;
    if (clear_p) begin
      state_nx = GET_A;
      in0_nx   = '0;
      in1_nx   = '0;
      sel_nx   = '0;
    end else if (load_p) begin
      unique case (state_q)
        GET_A: begin
          in0_nx   = sw;
          state_nx = GET_B;
        end
        GET_B: begin
          in1_nx   = sw;
          state_nx = GET_OP;
        end
        GET_OP: begin
          sel_nx   = sw[SEL_W-1:0];
          state_nx = SHOW;
        end
        SHOW: begin
          state_nx = GET_A;
        end
        default: state_nx = GET_A;
      endcase
    end
    oe_nx = (state_nx == SHOW);
  end

  assign state = 2'(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// Randomised bench for operand_loader with an in-bench behavioural model
// and a few literal checkpoints.
module tb_operand_loader;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw;
  logic          btn_load;
  logic          btn_clear;
  logic [W-1:0]  in0;
  logic [W-1:0]  in1;
  logic [SW-1:0] sel;
  logic          oe;
  logic [1:0]    state;

  operand_loader #(.WIDTH(W), .SEL_W(SW), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .oe        (oe),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a button press registers when the synchronised sample (raw two
  // edges late) has disagreed with the debounced level for D+1 edges in a row.
  bit m_raw [2][2];
  bit m_win [2][D+1];
  bit m_lvl [2];
  bit m_pend[2];
  bit nb    [2];
  bit s_smp;
  bit all_diff;
  int e_in0, e_in1, e_sel, e_st;

  always @(posedge clk) begin
    nb[0] = btn_load;
    nb[1] = btn_clear;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_raw[b][0] = 1'b0;
        m_raw[b][1] = 1'b0;
        for (int i = 0; i <= int'(D); i++) m_win[b][i] = 1'b0;
        m_lvl[b]  = 1'b0;
        m_pend[b] = 1'b0;
      end
      e_in0 = 0; e_in1 = 0; e_sel = 0; e_st = 0;
    end else begin
      if (m_pend[1]) begin
        e_in0 = 0; e_in1 = 0; e_sel = 0; e_st = 0;
      end else if (m_pend[0]) begin
        case (e_st)
          0: e_in0 = int'(sw);
          1: e_in1 = int'(sw);
          2: e_sel = int'(sw) % 4;
          default: ;
        endcase
        e_st = (e_st + 1) % 4;
      end
      for (int b = 0; b < 2; b++) begin
        s_smp = m_raw[b][1];
        for (int i = 0; i < int'(D); i++) m_win[b][i] = m_win[b][i+1];
        m_win[b][D] = s_smp;
        all_diff = 1'b1;
        for (int i = 0; i <= int'(D); i++)
          if (m_win[b][i] == m_lvl[b]) all_diff = 1'b0;
        m_pend[b] = 1'b0;
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_pend[b] = m_lvl[b];
        end
        m_raw[b][1] = m_raw[b][0];
        m_raw[b][0] = nb[b];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in0",   int'(in0),   e_in0);
      check("m_in1",   int'(in1),   e_in1);
      check("m_sel",   int'(sel),   e_sel);
      check("m_state", int'(state), e_st);
      check("m_oe",    int'(oe),    (e_st == 3) ? 1 : 0);
    end
  end

  task automatic press(input bit ld, input bit cl, input logic [W-1:0] v,
                       input int hold, input int low);
    sw        = v;
    btn_load  = ld;
    btn_clear = cl;
    repeat (hold) @(negedge clk);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic lit(input string name, input int s, input int a, input int b,
                     input int c, input int o);
    check({name, "_state"}, int'(state), s);
    check({name, "_in0"},   int'(in0),   a);
    check({name, "_in1"},   int'(in1),   b);
    check({name, "_sel"},   int'(sel),   c);
    check({name, "_oe"},    int'(oe),    o);
  endtask

  initial begin
    rst = 1'b1; btn_load = 1'b0; btn_clear = 1'b0; sw = 4'hF;
    repeat (3) @(negedge clk);
    lit("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // First capture lands exactly D+3 edges after the press is sampled.
    sw = 4'd3; btn_load = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("lat_before", int'(state), 0);
    @(posedge clk);
    #1 check("lat_state", int'(state), 1);
    check("lat_in0", int'(in0), 3);
    repeat (2) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);

    press(1'b1, 1'b0, 4'd5, 10, 10);
    press(1'b1, 1'b0, 4'd2, 10, 10);
    lit("entry", 3, 3, 5, 2, 1);

    press(1'b1, 1'b0, 4'd4, 3, 10);
    lit("glitch", 3, 3, 5, 2, 1);

    press(1'b1, 1'b0, 4'd9, 10, 10);
    lit("wrap", 0, 3, 5, 2, 0);
    press(1'b1, 1'b0, 4'd9, 10, 10);
    lit("wrap_next", 1, 9, 5, 2, 0);

    press(1'b1, 1'b1, 4'd6, 10, 10);
    lit("clr_prio", 0, 0, 0, 0, 0);

    // Reset lands while the load press is still being debounced.
    sw = 4'd7; btn_load = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1 lit("rst_mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 250; k++) begin
      int r;
      bit cl, ld;
      r = int'($urandom_range(0, 29));
      if (r == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end else begin
        cl = ($urandom_range(0, 7) == 0);
        ld = !cl || ($urandom_range(0, 1) == 1);
        press(ld, cl, W'($urandom), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)));
      end
    end
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
